// File: rtl/cop_ise_mc.sv
// cop_ise_mc: registered multi-cycle ISE co-processor port (rori.n/b/h, swapmove, iterative rori.w).
// Latency: miss 0 cycles; single-cycle ops respond 1 cycle after accept; rori.w after 1+ceil(imm/ROT_STEP).
// Backpressure: result held in res_q with cop_wr high until cop_rdywr; cop_valid low aborts to IDLE.
module cop_ise_mc #(
    parameter logic [2:0] ISE_V    = 3'b111,
    parameter int         ROT_STEP = 4
) (
    input  logic        cop_clk,
    input  logic        cop_rst,
    input  logic        cop_valid,
    input  logic        cop_rdywr,
    output logic        cop_ready,
    output logic        cop_wait,
    output logic        cop_wr,
    input  logic [31:0] cop_insn,
    input  logic [31:0] cop_rs1,
    input  logic [31:0] cop_rs2,
    output logic [31:0] cop_rd
);
    localparam logic [6:0] CUSTOM_0 = 7'b0001011;
    localparam logic [6:0] CUSTOM_2 = 7'b1011011;
    localparam logic [4:0] STEP     = 5'(ROT_STEP);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    typedef struct packed {
        logic rori_n;
        logic rori_b;
        logic rori_h;
        logic swapmove;
        logic rori_w;
    } dec_t;

    state_t      state_q, state_d;
    dec_t        dec;
    logic [4:0]  imm;
    logic [1:0]  fsel;
    logic        hit, accept, rorw_multi;
    logic [31:0] rv_res, sm_res, res_single, res_rot;
    logic [31:0] res_q;
    logic [4:0]  cnt_q, cnt_nxt;
    logic        unused_insn;

    function automatic logic [31:0] ror_n(input logic [31:0] x, input logic [1:0] sh);
        logic [7:0] d;
        ror_n = '0;
        for (int i = 0; i < 8; i++) begin
            d = {x[4*i +: 4], x[4*i +: 4]} >> sh;
            ror_n[4*i +: 4] = d[3:0];
        end
    endfunction

    function automatic logic [31:0] ror_b(input logic [31:0] x, input logic [2:0] sh);
        logic [15:0] d;
        ror_b = '0;
        for (int i = 0; i < 4; i++) begin
            d = {x[8*i +: 8], x[8*i +: 8]} >> sh;
            ror_b[8*i +: 8] = d[7:0];
        end
    endfunction

    function automatic logic [31:0] ror_h(input logic [31:0] x, input logic [3:0] sh);
        logic [31:0] d;
        ror_h = '0;
        for (int i = 0; i < 2; i++) begin
            d = {x[16*i +: 16], x[16*i +: 16]} >> sh;
            ror_h[16*i +: 16] = d[15:0];
        end
    endfunction

    function automatic logic [31:0] ror_w(input logic [31:0] x, input logic [4:0] sh);
        logic [63:0] d;
        d     = {x, x} >> sh;
        ror_w = d[31:0];
    endfunction

    assign imm         = cop_insn[29:25];
    assign fsel        = cop_insn[31:30];
    assign unused_insn = ^cop_insn[24:7];

    always_comb begin
        dec = '0;
        if (cop_insn[6:0] == CUSTOM_0) begin
            dec.rori_n   = ISE_V[0] && (fsel == 2'b01);
            dec.rori_b   = ISE_V[0] && (fsel == 2'b10);
            dec.rori_h   = ISE_V[0] && (fsel == 2'b11);
            dec.swapmove = ISE_V[1] && (fsel == 2'b00);
        end
        if (cop_insn[6:0] == CUSTOM_2) begin
            dec.rori_w = ISE_V[2] && (fsel == 2'b00);
        end
    end

    assign hit        = (dec != '0);
    assign accept     = (state_q == IDLE) && cop_valid && hit;
    assign rorw_multi = dec.rori_w && (imm != 5'd0);

    generate
        if (ISE_V[0]) begin : g_rv
            always_comb begin
                if (dec.rori_n)      rv_res = ror_n(cop_rs1, imm[1:0]);
                else if (dec.rori_b) rv_res = ror_b(cop_rs1, imm[2:0]);
                else if (dec.rori_h) rv_res = ror_h(cop_rs1, imm[3:0]);
                else                 rv_res = '0;
            end
        end else begin : g_no_rv
            assign rv_res = '0;
        end

        if (ISE_V[1]) begin : g_sm
            logic [31:0] sm_t;
            assign sm_t   = ((cop_rs1 >> imm) ^ cop_rs1) & cop_rs2;
            assign sm_res = cop_rs1 ^ sm_t ^ (sm_t << imm);
        end else begin : g_no_sm
            assign sm_res = '0;
        end

        // Rotator retires min(ROT_STEP, remaining) bits per EXEC cycle.
        if (ISE_V[2]) begin : g_rw
            logic [4:0] step;
            assign step    = (cnt_q < STEP) ? cnt_q : STEP;
            assign cnt_nxt = cnt_q - step;
            assign res_rot = ror_w(res_q, step);
        end else begin : g_no_rw
            assign cnt_nxt = '0;
            assign res_rot = res_q;
        end
    endgenerate

    always_comb begin
        if (dec.swapmove)    res_single = sm_res;
        else if (dec.rori_w) res_single = cop_rs1;
        else                 res_single = rv_res;
    end

    always_ff @(posedge cop_clk) begin
        if (cop_rst) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (cop_valid && hit) state_d = rorw_multi ? EXEC : RESP;
            EXEC: begin
                if (!cop_valid)            state_d = IDLE;
                else if (cnt_nxt == 5'd0)  state_d = RESP;
            end
            RESP: if (!cop_valid || cop_rdywr) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cop_ready = 1'b0;
        cop_wait  = 1'b0;
        cop_wr    = 1'b0;
        cop_rd    = '0;
        unique case (state_q)
            IDLE: begin
                cop_ready = cop_valid && !hit;
                cop_wait  = accept;
            end
            EXEC: cop_wait = 1'b1;
            RESP: begin
                cop_wr    = cop_valid;
                cop_ready = cop_valid && cop_rdywr;
            end
            default: ;
        endcase
        // A reset cycle never retires or writes, whatever state it interrupts.
        if (cop_rst) begin
            cop_ready = 1'b0;
            cop_wr    = 1'b0;
        end
        if (cop_wr) cop_rd = res_q;
    end

    always_ff @(posedge cop_clk) begin
        if (cop_rst) begin
            res_q <= '0;
            cnt_q <= '0;
        end else if (accept) begin
            res_q <= res_single;
            cnt_q <= dec.rori_w ? imm : 5'd0;
        end else if ((state_q == EXEC) && cop_valid) begin
            res_q <= res_rot;
            cnt_q <= cnt_nxt;
        end
    end
endmodule

// File: tb/tb_cop_ise_mc.sv
// Directed bench for cop_ise_mc: default build, ROT_STEP=1 build and a build with rori.w disabled.
`timescale 1ns/1ps
module tb_cop_ise_mc;
    localparam logic [6:0] C0 = 7'b0001011;
    localparam logic [6:0] C2 = 7'b1011011;
    localparam logic [6:0] C3 = 7'b1111011;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] insn, rs1, rs2;
    logic        valid [3];
    logic        rdywr [3];
    logic        ready [3];
    logic        waitq [3];
    logic        wr    [3];
    logic [31:0] rd    [3];
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    cop_ise_mc #(.ISE_V(3'b111), .ROT_STEP(4)) u0 (
        .cop_clk(clk), .cop_rst(rst), .cop_valid(valid[0]), .cop_rdywr(rdywr[0]),
        .cop_ready(ready[0]), .cop_wait(waitq[0]), .cop_wr(wr[0]),
        .cop_insn(insn), .cop_rs1(rs1), .cop_rs2(rs2), .cop_rd(rd[0]));

    cop_ise_mc #(.ISE_V(3'b111), .ROT_STEP(1)) u1 (
        .cop_clk(clk), .cop_rst(rst), .cop_valid(valid[1]), .cop_rdywr(rdywr[1]),
        .cop_ready(ready[1]), .cop_wait(waitq[1]), .cop_wr(wr[1]),
        .cop_insn(insn), .cop_rs1(rs1), .cop_rs2(rs2), .cop_rd(rd[1]));

    cop_ise_mc #(.ISE_V(3'b011), .ROT_STEP(4)) u2 (
        .cop_clk(clk), .cop_rst(rst), .cop_valid(valid[2]), .cop_rdywr(rdywr[2]),
        .cop_ready(ready[2]), .cop_wait(waitq[2]), .cop_wr(wr[2]),
        .cop_insn(insn), .cop_rs1(rs1), .cop_rs2(rs2), .cop_rd(rd[2]));

    function automatic logic [31:0] enc(input logic [6:0] opc, input logic [1:0] f, input logic [4:0] imm);
        enc = {f, imm, 18'd0, opc};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            checks++; if (ready[k] !== 1'b0) begin errors++; $display("FAIL reset_ready[%0d]: got %b expected 0", k, ready[k]); end
            checks++; if (waitq[k] !== 1'b0) begin errors++; $display("FAIL reset_wait[%0d]: got %b expected 0", k, waitq[k]); end
            checks++; if (wr[k] !== 1'b0)    begin errors++; $display("FAIL reset_wr[%0d]: got %b expected 0", k, wr[k]); end
            checks++; if (rd[k] !== 32'h0)   begin errors++; $display("FAIL reset_rd[%0d]: got %h expected 0", k, rd[k]); end
        end
    endtask

    task automatic test_single_cycle();
        logic [31:0] t_insn [5];
        logic [31:0] t_rs1  [5];
        logic [31:0] t_rs2  [5];
        logic [31:0] t_exp  [5];
        string       t_name [5];
        t_insn[0] = enc(C0, 2'b01, 5'd1);  t_rs1[0] = 32'h12345678; t_rs2[0] = 32'h0;        t_exp[0] = 32'h8192A3B4; t_name[0] = "rori_n";
        t_insn[1] = enc(C0, 2'b10, 5'd4);  t_rs1[1] = 32'h12345678; t_rs2[1] = 32'h0;        t_exp[1] = 32'h21436587; t_name[1] = "rori_b";
        t_insn[2] = enc(C0, 2'b11, 5'd8);  t_rs1[2] = 32'h12345678; t_rs2[2] = 32'h0;        t_exp[2] = 32'h34127856; t_name[2] = "rori_h";
        t_insn[3] = enc(C0, 2'b00, 5'd16); t_rs1[3] = 32'h0000FFFF; t_rs2[3] = 32'h0000FFFF; t_exp[3] = 32'hFFFF0000; t_name[3] = "swapmove16";
        t_insn[4] = enc(C0, 2'b00, 5'd1);  t_rs1[4] = 32'h00000002; t_rs2[4] = 32'h00000001; t_exp[4] = 32'h00000001; t_name[4] = "swapmove1";
        for (int i = 0; i < 5; i++) begin
            tick();
            insn = t_insn[i]; rs1 = t_rs1[i]; rs2 = t_rs2[i];
            rdywr[0] = 1'b1; valid[0] = 1'b1;
            @(negedge clk);
            checks++; if (waitq[0] !== 1'b1) begin errors++; $display("FAIL %s_c0_wait: got %b expected 1", t_name[i], waitq[0]); end
            checks++; if (ready[0] !== 1'b0) begin errors++; $display("FAIL %s_c0_ready: got %b expected 0", t_name[i], ready[0]); end
            checks++; if (wr[0] !== 1'b0)    begin errors++; $display("FAIL %s_c0_wr: got %b expected 0", t_name[i], wr[0]); end
            tick();
            @(negedge clk);
            checks++; if (wr[0] !== 1'b1)    begin errors++; $display("FAIL %s_c1_wr: got %b expected 1", t_name[i], wr[0]); end
            checks++; if (rd[0] !== t_exp[i]) begin errors++; $display("FAIL %s_c1_rd: got %h expected %h", t_name[i], rd[0], t_exp[i]); end
            checks++; if (ready[0] !== 1'b1) begin errors++; $display("FAIL %s_c1_ready: got %b expected 1", t_name[i], ready[0]); end
            checks++; if (waitq[0] !== 1'b0) begin errors++; $display("FAIL %s_c1_wait: got %b expected 0", t_name[i], waitq[0]); end
            tick();
            valid[0] = 1'b0;
            @(negedge clk);
            checks++; if (wr[0] !== 1'b0)    begin errors++; $display("FAIL %s_idle_wr: got %b expected 0", t_name[i], wr[0]); end
        end
    endtask

    task automatic test_rori_w();
        int          t_k   [5];
        logic [4:0]  t_imm [5];
        int          t_n   [5];
        logic [31:0] t_exp [5];
        int          k;
        t_k[0] = 0; t_imm[0] = 5'd9;  t_n[0] = 3; t_exp[0] = 32'h00C00000;
        t_k[1] = 1; t_imm[1] = 5'd9;  t_n[1] = 9; t_exp[1] = 32'h00C00000;
        t_k[2] = 0; t_imm[2] = 5'd0;  t_n[2] = 0; t_exp[2] = 32'h80000001;
        t_k[3] = 0; t_imm[3] = 5'd31; t_n[3] = 8; t_exp[3] = 32'h00000003;
        t_k[4] = 1; t_imm[4] = 5'd1;  t_n[4] = 1; t_exp[4] = 32'hC0000000;
        for (int i = 0; i < 5; i++) begin
            k = t_k[i];
            tick();
            insn = enc(C2, 2'b00, t_imm[i]); rs1 = 32'h80000001; rs2 = 32'h0;
            rdywr[k] = 1'b1; valid[k] = 1'b1;
            for (int c = 0; c <= t_n[i]; c++) begin
                @(negedge clk);
                checks++; if (waitq[k] !== 1'b1) begin errors++; $display("FAIL rori_w%0d_c%0d_wait: got %b expected 1", i, c, waitq[k]); end
                checks++; if (wr[k] !== 1'b0)    begin errors++; $display("FAIL rori_w%0d_c%0d_wr: got %b expected 0", i, c, wr[k]); end
                tick();
            end
            @(negedge clk);
            checks++; if (wr[k] !== 1'b1)     begin errors++; $display("FAIL rori_w%0d_resp_wr: got %b expected 1", i, wr[k]); end
            checks++; if (rd[k] !== t_exp[i]) begin errors++; $display("FAIL rori_w%0d_resp_rd: got %h expected %h", i, rd[k], t_exp[i]); end
            checks++; if (ready[k] !== 1'b1)  begin errors++; $display("FAIL rori_w%0d_resp_ready: got %b expected 1", i, ready[k]); end
            checks++; if (waitq[k] !== 1'b0)  begin errors++; $display("FAIL rori_w%0d_resp_wait: got %b expected 0", i, waitq[k]); end
            tick();
            valid[k] = 1'b0;
        end
    endtask

    task automatic test_backpressure();
        tick();
        insn = enc(C0, 2'b01, 5'd1); rs1 = 32'h12345678; rs2 = 32'h0;
        rdywr[0] = 1'b0; valid[0] = 1'b1;
        @(negedge clk);
        tick();
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            checks++; if (wr[0] !== 1'b1)         begin errors++; $display("FAIL bp_c%0d_wr: got %b expected 1", c, wr[0]); end
            checks++; if (ready[0] !== 1'b0)      begin errors++; $display("FAIL bp_c%0d_ready: got %b expected 0", c, ready[0]); end
            checks++; if (rd[0] !== 32'h8192A3B4) begin errors++; $display("FAIL bp_c%0d_rd: got %h expected 8192a3b4", c, rd[0]); end
            tick();
        end
        rdywr[0] = 1'b1;
        @(negedge clk);
        checks++; if (ready[0] !== 1'b1)      begin errors++; $display("FAIL bp_release_ready: got %b expected 1", ready[0]); end
        checks++; if (rd[0] !== 32'h8192A3B4) begin errors++; $display("FAIL bp_release_rd: got %h expected 8192a3b4", rd[0]); end
        tick();
        @(negedge clk);
        checks++; if (wr[0] !== 1'b0)    begin errors++; $display("FAIL bp_idle_wr: got %b expected 0", wr[0]); end
        checks++; if (waitq[0] !== 1'b1) begin errors++; $display("FAIL bp_idle_reissue_wait: got %b expected 1", waitq[0]); end
        tick();
        valid[0] = 1'b0;
        @(negedge clk);
        checks++; if (wr[0] !== 1'b0)    begin errors++; $display("FAIL bp_abort_wr: got %b expected 0", wr[0]); end
        tick();
    endtask

    task automatic test_miss();
        tick();
        insn = enc(C3, 2'b01, 5'd1); rs1 = 32'h12345678; rs2 = 32'h0;
        valid[0] = 1'b1; rdywr[0] = 1'b1;
        @(negedge clk);
        checks++; if (ready[0] !== 1'b1) begin errors++; $display("FAIL miss_ready: got %b expected 1", ready[0]); end
        checks++; if (wr[0] !== 1'b0)    begin errors++; $display("FAIL miss_wr: got %b expected 0", wr[0]); end
        checks++; if (waitq[0] !== 1'b0) begin errors++; $display("FAIL miss_wait: got %b expected 0", waitq[0]); end
        tick();
        valid[0] = 1'b0;
        insn = enc(C2, 2'b00, 5'd9); rs1 = 32'h80000001;
        valid[2] = 1'b1; rdywr[2] = 1'b1;
        @(negedge clk);
        checks++; if (ready[2] !== 1'b1) begin errors++; $display("FAIL dis_rori_w_ready: got %b expected 1", ready[2]); end
        checks++; if (wr[2] !== 1'b0)    begin errors++; $display("FAIL dis_rori_w_wr: got %b expected 0", wr[2]); end
        checks++; if (waitq[2] !== 1'b0) begin errors++; $display("FAIL dis_rori_w_wait: got %b expected 0", waitq[2]); end
        tick();
        insn = enc(C0, 2'b01, 5'd1); rs1 = 32'h12345678;
        @(negedge clk);
        checks++; if (waitq[2] !== 1'b1) begin errors++; $display("FAIL dis_rori_n_wait: got %b expected 1", waitq[2]); end
        tick();
        @(negedge clk);
        checks++; if (rd[2] !== 32'h8192A3B4) begin errors++; $display("FAIL dis_rori_n_rd: got %h expected 8192a3b4", rd[2]); end
        tick();
        valid[2] = 1'b0;
    endtask

    task automatic test_abort();
        tick();
        insn = enc(C2, 2'b00, 5'd9); rs1 = 32'h80000001; rs2 = 32'h0;
        valid[0] = 1'b1; rdywr[0] = 1'b1;
        @(negedge clk);
        tick();
        @(negedge clk);
        checks++; if (waitq[0] !== 1'b1) begin errors++; $display("FAIL abort_exec1_wait: got %b expected 1", waitq[0]); end
        tick();
        valid[0] = 1'b0;
        @(negedge clk);
        checks++; if (wr[0] !== 1'b0)    begin errors++; $display("FAIL abort_exec2_wr: got %b expected 0", wr[0]); end
        tick();
        // Re-issue: from IDLE this is a fresh accept, so RESP comes 4 cycles later.
        valid[0] = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checks++; if (wr[0] !== 1'b0)    begin errors++; $display("FAIL abort_restart_c%0d_wr: got %b expected 0", c, wr[0]); end
            checks++; if (waitq[0] !== 1'b1) begin errors++; $display("FAIL abort_restart_c%0d_wait: got %b expected 1", c, waitq[0]); end
            tick();
        end
        @(negedge clk);
        checks++; if (wr[0] !== 1'b1)         begin errors++; $display("FAIL abort_restart_wr: got %b expected 1", wr[0]); end
        checks++; if (rd[0] !== 32'h00C00000) begin errors++; $display("FAIL abort_restart_rd: got %h expected 00c00000", rd[0]); end
        tick();
        valid[0] = 1'b0;
    endtask

    task automatic test_reset_resp();
        tick();
        insn = enc(C0, 2'b01, 5'd1); rs1 = 32'h12345678; rs2 = 32'h0;
        valid[0] = 1'b1; rdywr[0] = 1'b0;
        @(negedge clk);
        tick();
        @(negedge clk);
        checks++; if (wr[0] !== 1'b1) begin errors++; $display("FAIL rst_resp_wr: got %b expected 1", wr[0]); end
        rst = 1'b1;
        tick();
        rst = 1'b0; valid[0] = 1'b0;
        @(negedge clk);
        checks++; if (ready[0] !== 1'b0) begin errors++; $display("FAIL rst_after_ready: got %b expected 0", ready[0]); end
        checks++; if (waitq[0] !== 1'b0) begin errors++; $display("FAIL rst_after_wait: got %b expected 0", waitq[0]); end
        checks++; if (wr[0] !== 1'b0)    begin errors++; $display("FAIL rst_after_wr: got %b expected 0", wr[0]); end
        checks++; if (rd[0] !== 32'h0)   begin errors++; $display("FAIL rst_after_rd: got %h expected 0", rd[0]); end
        tick();
        rs1 = 32'h00000001; rdywr[0] = 1'b1; valid[0] = 1'b1;
        @(negedge clk);
        checks++; if (waitq[0] !== 1'b1) begin errors++; $display("FAIL rst_next_c0_wait: got %b expected 1", waitq[0]); end
        tick();
        @(negedge clk);
        checks++; if (wr[0] !== 1'b1)         begin errors++; $display("FAIL rst_next_wr: got %b expected 1", wr[0]); end
        checks++; if (rd[0] !== 32'h00000008) begin errors++; $display("FAIL rst_next_rd: got %h expected 00000008", rd[0]); end
        checks++; if (ready[0] !== 1'b1)      begin errors++; $display("FAIL rst_next_ready: got %b expected 1", ready[0]); end
        tick();
        valid[0] = 1'b0;
    endtask

    task automatic test_back_to_back();
        tick();
        insn = enc(C0, 2'b01, 5'd1); rs1 = 32'h12345678; rs2 = 32'h0;
        valid[0] = 1'b1; rdywr[0] = 1'b1;
        @(negedge clk);
        tick();
        @(negedge clk);
        checks++; if (rd[0] !== 32'h8192A3B4) begin errors++; $display("FAIL b2b_first_rd: got %h expected 8192a3b4", rd[0]); end
        checks++; if (ready[0] !== 1'b1)      begin errors++; $display("FAIL b2b_first_ready: got %b expected 1", ready[0]); end
        tick();
        insn = enc(C0, 2'b10, 5'd4); rs1 = 32'hA5C30F96;
        @(negedge clk);
        checks++; if (waitq[0] !== 1'b1) begin errors++; $display("FAIL b2b_second_accept_wait: got %b expected 1", waitq[0]); end
        checks++; if (wr[0] !== 1'b0)    begin errors++; $display("FAIL b2b_second_accept_wr: got %b expected 0", wr[0]); end
        tick();
        @(negedge clk);
        checks++; if (wr[0] !== 1'b1)         begin errors++; $display("FAIL b2b_second_wr: got %b expected 1", wr[0]); end
        checks++; if (rd[0] !== 32'h5A3CF069) begin errors++; $display("FAIL b2b_second_rd: got %h expected 5a3cf069", rd[0]); end
        tick();
        valid[0] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        insn = 32'h0; rs1 = 32'h0; rs2 = 32'h0;
        for (int k = 0; k < 3; k++) begin
            valid[k] = 1'b0;
            rdywr[k] = 1'b1;
        end
        test_reset();
        test_single_cycle();
        test_rori_w();
        test_backpressure();
        test_miss();
        test_abort();
        test_reset_resp();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
